// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry elastic FIFO between IF1 and IF2. Each entry
// carries LANES fetch slots (PC + {brtype, pcpre}) and a per-lane valid mask.
// Valid/ready on both sides, single-cycle flush, no input-to-output comb path.
module if_fetch_queue #(
    parameter int LANES  = 2,
    parameter int PC_W   = 32,
    parameter int META_W = 34,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_valid,
    input  logic [LANES-1:0]            i_lane_mask,
    input  logic [LANES*PC_W-1:0]       i_pc,
    input  logic [LANES*META_W-1:0]     i_meta,
    output logic                        o_ready,
    input  logic                        flush,
    output logic                        o_valid,
    output logic [LANES-1:0]            o_lane_mask,
    output logic [LANES*PC_W-1:0]       o_pc,
    output logic [LANES*META_W-1:0]     o_meta,
    input  logic                        i_ready,
    output logic [$clog2(DEPTH+1)-1:0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = LANES * (1 + PC_W + META_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Entry layout: {mask, pc, meta}
    logic [ENT_W-1:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      push;
    logic                      pop;
    logic [ENT_W-1:0]          head;
    logic [LANES-1:0]          head_mask;
    logic [LANES*PC_W-1:0]     head_pc;
    logic [LANES*META_W-1:0]   head_meta;

    // Ready depends only on occupancy so upstream never sees a path from i_ready.
    assign o_ready = (count_q != FULL);
    assign o_valid = (count_q != '0) & ~flush;
    // An all-zero mask completes the handshake but is not stored.
    assign push    = i_valid & o_ready & ~flush & (|i_lane_mask);
    assign pop     = o_valid & i_ready;
    assign o_count = count_q;

    assign head      = mem_q[rd_ptr_q];
    assign head_mask = head[ENT_W-1 -: LANES];
    assign head_pc   = head[LANES*META_W +: LANES*PC_W];
    assign head_meta = head[0 +: LANES*META_W];

    // Head outputs are forced to zero whenever nothing valid is presented.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign o_lane_mask[gi]             = head_mask[gi] & o_valid;
            assign o_pc[gi*PC_W +: PC_W]       = head_pc[gi*PC_W +: PC_W] & {PC_W{o_valid}};
            assign o_meta[gi*META_W +: META_W] = head_meta[gi*META_W +: META_W] & {META_W{o_valid}};
        end
    endgenerate

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; never reset, validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {i_lane_mask, i_pc, i_meta};
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a DEPTH=2 instance for reset, streaming,
// fill/stall, mask and flush scenarios, and a DEPTH=4 instance for wrap-around.
module tb_if_fetch_queue;
    logic clk;
    logic rstn;

    // DEPTH=2 instance
    logic        valid2, ready2o, flush2, ovalid2, iready2;
    logic [1:0]  mask2, omask2, count2;
    logic [63:0] pc2, opc2;
    logic [67:0] meta2, ometa2;

    // DEPTH=4 instance
    logic        valid4, ready4o, flush4, ovalid4, iready4;
    logic [1:0]  mask4, omask4;
    logic [2:0]  count4;
    logic [63:0] pc4, opc4;
    logic [67:0] meta4, ometa4;

    int checks = 0;
    int fails  = 0;

    if_fetch_queue #(.LANES(2), .PC_W(32), .META_W(34), .DEPTH(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .i_valid(valid2), .i_lane_mask(mask2), .i_pc(pc2), .i_meta(meta2),
        .o_ready(ready2o), .flush(flush2),
        .o_valid(ovalid2), .o_lane_mask(omask2), .o_pc(opc2), .o_meta(ometa2),
        .i_ready(iready2), .o_count(count2)
    );

    if_fetch_queue #(.LANES(2), .PC_W(32), .META_W(34), .DEPTH(4)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .i_valid(valid4), .i_lane_mask(mask4), .i_pc(pc4), .i_meta(meta4),
        .o_ready(ready4o), .flush(flush4),
        .o_valid(ovalid4), .o_lane_mask(omask4), .o_pc(opc4), .o_meta(ometa4),
        .i_ready(iready4), .o_count(count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Entry n: lane0 PC = 0x1c000000 + 8n, lane1 PC = lane0 + 4
    function automatic logic [63:0] mk_pc(input int n);
        logic [31:0] p0;
        p0 = 32'h1c00_0000 + 32'(n * 8);
        return {p0 + 32'd4, p0};
    endfunction

    function automatic logic [67:0] mk_meta(input int n);
        logic [31:0] p0;
        p0 = 32'h1c00_0000 + 32'(n * 8);
        return {2'b10, p0 + 32'h104, 2'b01, p0 + 32'h100};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic offer2(input int n, input logic [1:0] m);
        valid2 = 1'b1;
        mask2  = m;
        pc2    = mk_pc(n);
        meta2  = mk_meta(n);
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        if (ovalid2 !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", ovalid2); fails++; end
        checks++;
        if (ready2o !== 1'b1) begin $display("FAIL reset_ready: got %b expected 1", ready2o); fails++; end
        checks++;
        if (count2 !== 2'd0) begin $display("FAIL reset_count: got %0d expected 0", count2); fails++; end
        checks++;
        if (opc2 !== 64'd0 || omask2 !== 2'b00 || ometa2 !== 68'd0) begin
            $display("FAIL reset_payload: got pc=%h mask=%b meta=%h expected zeros", opc2, omask2, ometa2); fails++;
        end
        checks++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_stream;
        step;
        iready2 = 1'b1;
        offer2(0, 2'b11);
        #1;
        if (ovalid2 !== 1'b0) begin $display("FAIL stream_empty_valid: got %b expected 0", ovalid2); fails++; end
        checks++;
        step;
        $display("txn stream push pc=%h", mk_pc(0));
        if (ovalid2 !== 1'b1 || opc2 !== mk_pc(0) || ometa2 !== mk_meta(0) || omask2 !== 2'b11) begin
            $display("FAIL stream_head0: got v=%b pc=%h mask=%b expected v=1 pc=%h mask=11", ovalid2, opc2, omask2, mk_pc(0)); fails++;
        end
        checks++;
        offer2(1, 2'b11);
        step;
        $display("txn stream push pc=%h", mk_pc(1));
        if (ovalid2 !== 1'b1 || opc2 !== mk_pc(1) || count2 !== 2'd1) begin
            $display("FAIL stream_head1: got v=%b pc=%h cnt=%0d expected v=1 pc=%h cnt=1", ovalid2, opc2, count2, mk_pc(1)); fails++;
        end
        checks++;
        valid2 = 1'b0;
        step;
        if (ovalid2 !== 1'b0 || count2 !== 2'd0) begin
            $display("FAIL stream_drain: got v=%b cnt=%0d expected v=0 cnt=0", ovalid2, count2); fails++;
        end
        checks++;
    endtask

    task automatic test_fill;
        iready2 = 1'b0;
        offer2(2, 2'b11);
        step;
        offer2(3, 2'b11);
        step;
        if (count2 !== 2'd2 || ready2o !== 1'b0) begin
            $display("FAIL fill_full: got cnt=%0d rdy=%b expected cnt=2 rdy=0", count2, ready2o); fails++;
        end
        checks++;
        offer2(4, 2'b11);
        step;
        if (count2 !== 2'd2 || opc2 !== mk_pc(2)) begin
            $display("FAIL fill_stall: got cnt=%0d pc=%h expected cnt=2 pc=%h", count2, opc2, mk_pc(2)); fails++;
        end
        checks++;
        iready2 = 1'b1;
        step;
        $display("txn fill pop pc=%h", mk_pc(2));
        if (count2 !== 2'd1 || opc2 !== mk_pc(3) || ready2o !== 1'b1) begin
            $display("FAIL fill_pop1: got cnt=%0d pc=%h rdy=%b expected cnt=1 pc=%h rdy=1", count2, opc2, ready2o, mk_pc(3)); fails++;
        end
        checks++;
        step;
        $display("txn fill pop pc=%h push pc=%h", mk_pc(3), mk_pc(4));
        if (count2 !== 2'd1 || opc2 !== mk_pc(4)) begin
            $display("FAIL fill_third: got cnt=%0d pc=%h expected cnt=1 pc=%h", count2, opc2, mk_pc(4)); fails++;
        end
        checks++;
        valid2 = 1'b0;
        step;
        if (count2 !== 2'd0 || ovalid2 !== 1'b0) begin
            $display("FAIL fill_drain: got cnt=%0d v=%b expected cnt=0 v=0", count2, ovalid2); fails++;
        end
        checks++;
    endtask

    task automatic test_mask;
        iready2 = 1'b0;
        offer2(5, 2'b01);
        step;
        if (omask2 !== 2'b01 || opc2 !== mk_pc(5) || count2 !== 2'd1) begin
            $display("FAIL mask_partial: got mask=%b pc=%h cnt=%0d expected mask=01 pc=%h cnt=1", omask2, opc2, count2, mk_pc(5)); fails++;
        end
        checks++;
        offer2(6, 2'b00);
        #1;
        if (ready2o !== 1'b1) begin $display("FAIL mask_zero_ready: got %b expected 1", ready2o); fails++; end
        checks++;
        step;
        if (count2 !== 2'd1 || opc2 !== mk_pc(5)) begin
            $display("FAIL mask_zero_count: got cnt=%0d pc=%h expected cnt=1 pc=%h", count2, opc2, mk_pc(5)); fails++;
        end
        checks++;
        valid2  = 1'b0;
        iready2 = 1'b1;
        step;
        if (count2 !== 2'd0) begin $display("FAIL mask_drain: got %0d expected 0", count2); fails++; end
        checks++;
    endtask

    task automatic test_flush;
        iready2 = 1'b0;
        offer2(7, 2'b11);
        step;
        offer2(8, 2'b11);
        step;
        offer2(9, 2'b11);
        flush2  = 1'b1;
        iready2 = 1'b1;
        #1;
        if (ovalid2 !== 1'b0 || omask2 !== 2'b00 || opc2 !== 64'd0) begin
            $display("FAIL flush_cycle: got v=%b mask=%b pc=%h expected zeros", ovalid2, omask2, opc2); fails++;
        end
        checks++;
        step;
        flush2 = 1'b0;
        valid2 = 1'b0;
        #1;
        if (count2 !== 2'd0 || ovalid2 !== 1'b0 || ready2o !== 1'b1) begin
            $display("FAIL flush_after: got cnt=%0d v=%b rdy=%b expected cnt=0 v=0 rdy=1", count2, ovalid2, ready2o); fails++;
        end
        checks++;
        offer2(10, 2'b10);
        step;
        valid2 = 1'b0;
        if (ovalid2 !== 1'b1 || opc2 !== mk_pc(10) || omask2 !== 2'b10 || count2 !== 2'd1) begin
            $display("FAIL flush_repush: got v=%b pc=%h mask=%b cnt=%0d expected v=1 pc=%h mask=10 cnt=1", ovalid2, opc2, omask2, count2, mk_pc(10)); fails++;
        end
        checks++;
        step;
    endtask

    task automatic test_wrap;
        logic [63:0] exp_q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit pu, po;
        step;
        while (got < 10 && cyc < 200) begin
            valid4  = (sent < 10);
            mask4   = 2'b11;
            pc4     = mk_pc(sent + 16);
            meta4   = mk_meta(sent + 16);
            iready4 = 1'($urandom_range(0, 1));
            #1;
            pu = valid4 && ready4o;
            po = ovalid4 && iready4;
            if (po) begin
                if (exp_q.size() == 0) begin
                    $display("FAIL wrap_spurious: got pc=%h expected no entry", opc4); fails++;
                end else begin
                    $display("txn wrap pop pc=%h", opc4);
                    if (opc4 !== exp_q[0]) begin
                        $display("FAIL wrap_order: got pc=%h expected %h", opc4, exp_q[0]); fails++;
                    end
                    void'(exp_q.pop_front());
                end
                checks++;
                got++;
            end
            if (pu) begin
                exp_q.push_back(pc4);
                sent++;
            end
            step;
            cyc++;
            if (count4 !== 3'(exp_q.size())) begin
                $display("FAIL wrap_count: got %0d expected %0d", count4, exp_q.size()); fails++;
            end
            checks++;
        end
        valid4  = 1'b0;
        iready4 = 1'b0;
        if (got != 10) begin $display("FAIL wrap_timeout: got %0d pops expected 10", got); fails++; end
        checks++;
    endtask

    task automatic test_async_reset;
        iready2 = 1'b0;
        offer2(11, 2'b11);
        step;
        offer2(12, 2'b11);
        step;
        valid2 = 1'b0;
        if (count2 !== 2'd2) begin $display("FAIL areset_pre: got %0d expected 2", count2); fails++; end
        checks++;
        #1;
        rstn = 1'b0;
        #1;
        if (ovalid2 !== 1'b0 || count2 !== 2'd0 || ready2o !== 1'b1 || opc2 !== 64'd0 || omask2 !== 2'b00 || ometa2 !== 68'd0) begin
            $display("FAIL areset_now: got v=%b cnt=%0d rdy=%b pc=%h mask=%b expected v=0 cnt=0 rdy=1 zeros", ovalid2, count2, ready2o, opc2, omask2); fails++;
        end
        checks++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        valid2 = 1'b0; mask2 = '0; pc2 = '0; meta2 = '0; flush2 = 1'b0; iready2 = 1'b0;
        valid4 = 1'b0; mask4 = '0; pc4 = '0; meta4 = '0; flush4 = 1'b0; iready4 = 1'b0;
        test_reset;
        test_stream;
        test_fill;
        test_mask;
        test_flush;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
